// File: rtl/debounce_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module : debounce_scan_ctrl
// Brief  : N-channel switch debouncer sharing one tick divider, with a
//          round-robin valid/ready edge-event output and sticky overflow flags.
// Rev    : 1.0  initial release
// ============================================================================
module debounce_scan_ctrl #(
    parameter int N_CH     = 4,
    parameter int TICK_DIV = 500000,
    parameter int CH_W     = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] sw,
    output logic [N_CH-1:0] db,
    output logic            evt_valid,
    input  logic            evt_ready,
    output logic [CH_W-1:0] evt_ch,
    output logic            evt_rise,
    output logic [N_CH-1:0] ovf,
    input  logic            ovf_clr
);

    localparam int              CNT_W      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [CH_W-1:0]  C_CH_LAST  = CH_W'(N_CH - 1);

    typedef enum logic [0:0] {
        CTRL_IDLE = 1'b0,
        CTRL_SCAN = 1'b1
    } ctrl_e;

    typedef enum logic [2:0] {
        ST_ZERO = 3'b000,
        ST_W1_1 = 3'b001,
        ST_W1_2 = 3'b010,
        ST_W1_3 = 3'b011,
        ST_W0_3 = 3'b100,
        ST_W0_2 = 3'b101,
        ST_W0_1 = 3'b110,
        ST_ONE  = 3'b111
    } ch_state_e;

    logic [N_CH-1:0]  sw_meta_q;
    logic [N_CH-1:0]  sw_s_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    ctrl_e            ctrl_q, ctrl_d;
    logic [CH_W-1:0]  idx_q, idx_d;
    ch_state_e        ch_q [N_CH];
    ch_state_e        ch_d [N_CH];
    logic [N_CH-1:0]  db_q, db_d;
    logic [N_CH-1:0]  pend_q, pend_d;
    logic [N_CH-1:0]  type_q, type_d;
    logic [N_CH-1:0]  ovf_q, ovf_d;
    logic             evt_valid_q, evt_valid_d;
    logic [CH_W-1:0]  evt_ch_q, evt_ch_d;
    logic             evt_rise_q, evt_rise_d;
    logic [CH_W-1:0]  rr_q, rr_d;

    logic             w_tick;
    logic             w_s;
    ch_state_e        w_slot_state;
    ch_state_e        w_slot_next;
    logic             w_slot_edge;
    logic             w_slot_rise;
    logic             w_hs;
    logic [N_CH-1:0]  w_edge_vec;
    logic [N_CH-1:0]  w_take_vec;
    logic             w_hi_any, w_lo_any;
    logic [CH_W-1:0]  w_hi_ch, w_lo_ch;
    logic             w_pick_any;
    logic [CH_W-1:0]  w_pick_ch;

    assign w_tick = (cnt_q == C_CNT_LAST);
    assign w_hs   = evt_valid_q & evt_ready;

    // Tick divider and sweep sequencer
    always_comb begin
        cnt_d  = w_tick ? '0 : cnt_q + CNT_W'(1);
        ctrl_d = ctrl_q;
        idx_d  = idx_q;
        case (ctrl_q)
            CTRL_IDLE: begin
                if (w_tick) begin
                    ctrl_d = CTRL_SCAN;
                    idx_d  = '0;
                end
            end
            CTRL_SCAN: begin
                if (idx_q == C_CH_LAST) begin
                    ctrl_d = CTRL_IDLE;
                end else begin
                    idx_d = idx_q + CH_W'(1);
                end
            end
            default: ctrl_d = CTRL_IDLE;
        endcase
    end

    // Debounce update of the single channel owning the current sweep slot
    always_comb begin
        w_slot_state = ch_q[idx_q];
        w_s          = sw_s_q[idx_q];
        w_slot_next  = w_slot_state;
        w_slot_edge  = 1'b0;
        w_slot_rise  = 1'b0;
        if (ctrl_q == CTRL_SCAN) begin
            case (w_slot_state)
                ST_ZERO: if (w_s) w_slot_next = ST_W1_1;
                ST_W1_1: w_slot_next = w_s ? ST_W1_2 : ST_ZERO;
                ST_W1_2: w_slot_next = w_s ? ST_W1_3 : ST_ZERO;
                ST_W1_3: begin
                    if (w_s) begin
                        w_slot_next = ST_ONE;
                        w_slot_edge = 1'b1;
                        w_slot_rise = 1'b1;
                    end else begin
                        w_slot_next = ST_ZERO;
                    end
                end
                ST_ONE:  if (!w_s) w_slot_next = ST_W0_3;
                ST_W0_3: w_slot_next = w_s ? ST_ONE : ST_W0_2;
                ST_W0_2: w_slot_next = w_s ? ST_ONE : ST_W0_1;
                ST_W0_1: begin
                    if (w_s) begin
                        w_slot_next = ST_ONE;
                    end else begin
                        w_slot_next = ST_ZERO;
                        w_slot_edge = 1'b1;
                    end
                end
                default: w_slot_next = ST_ZERO;
            endcase
        end
        for (int i = 0; i < N_CH; i++) begin
            ch_d[i] = ch_q[i];
        end
        if (ctrl_q == CTRL_SCAN) begin
            ch_d[idx_q] = w_slot_next;
        end
    end

    // Pending slots, overflow flags and debounced levels
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            w_edge_vec[i] = w_slot_edge && (idx_q == CH_W'(i));
            w_take_vec[i] = w_hs && (evt_ch_q == CH_W'(i));
        end
        pend_d = (pend_q & ~w_take_vec) | w_edge_vec;
        type_d = (type_q & ~w_edge_vec) | (w_edge_vec & {N_CH{w_slot_rise}});
        db_d   = (db_q & ~w_edge_vec) | (w_edge_vec & {N_CH{w_slot_rise}});
        ovf_d  = (ovf_q & ~{N_CH{ovf_clr}}) | (w_edge_vec & pend_q & ~w_take_vec);
    end

    // Round-robin pick: lowest pending channel at/after rr_q, else lowest overall
    always_comb begin
        w_hi_any = 1'b0;
        w_lo_any = 1'b0;
        w_hi_ch  = '0;
        w_lo_ch  = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                if (CH_W'(i) >= rr_q) begin
                    w_hi_any = 1'b1;
                    w_hi_ch  = CH_W'(i);
                end
                w_lo_any = 1'b1;
                w_lo_ch  = CH_W'(i);
            end
        end
        w_pick_any = w_lo_any;
        w_pick_ch  = w_hi_any ? w_hi_ch : w_lo_ch;
    end

    // An overwrite of the presented slot replaces its payload; evt_ch never moves
    always_comb begin
        evt_valid_d = evt_valid_q;
        evt_ch_d    = evt_ch_q;
        evt_rise_d  = evt_rise_q;
        rr_d        = rr_q;
        if (evt_valid_q) begin
            if (w_hs) begin
                evt_valid_d = 1'b0;
                rr_d        = (evt_ch_q == C_CH_LAST) ? '0 : evt_ch_q + CH_W'(1);
            end else begin
                evt_rise_d = type_d[evt_ch_q];
            end
        end else if (w_pick_any) begin
            evt_valid_d = 1'b1;
            evt_ch_d    = w_pick_ch;
            evt_rise_d  = type_d[w_pick_ch];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sw_meta_q   <= '0;
            sw_s_q      <= '0;
            cnt_q       <= '0;
            ctrl_q      <= CTRL_IDLE;
            idx_q       <= '0;
            for (int i = 0; i < N_CH; i++) begin
                ch_q[i] <= ST_ZERO;
            end
            db_q        <= '0;
            pend_q      <= '0;
            type_q      <= '0;
            ovf_q       <= '0;
            evt_valid_q <= 1'b0;
            evt_ch_q    <= '0;
            evt_rise_q  <= 1'b0;
            rr_q        <= '0;
        end else begin
            sw_meta_q   <= sw;
            sw_s_q      <= sw_meta_q;
            cnt_q       <= cnt_d;
            ctrl_q      <= ctrl_d;
            idx_q       <= idx_d;
            for (int i = 0; i < N_CH; i++) begin
                ch_q[i] <= ch_d[i];
            end
            db_q        <= db_d;
            pend_q      <= pend_d;
            type_q      <= type_d;
            ovf_q       <= ovf_d;
            evt_valid_q <= evt_valid_d;
            evt_ch_q    <= evt_ch_d;
            evt_rise_q  <= evt_rise_d;
            rr_q        <= rr_d;
        end
    end

    assign db        = db_q;
    assign evt_valid = evt_valid_q;
    assign evt_ch    = evt_ch_q;
    assign evt_rise  = evt_rise_q;
    assign ovf       = ovf_q;

endmodule
`default_nettype wire
